mux_scheduler: RTL and testbench

MUX_SCHEDULER -- requirements
Module: mux_scheduler

---
 rtl/mux_scheduler.sv | 114 +++++++++++
 tb/tb_mux_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scheduler.sv
// Round-robin mux/demux scheduler moving bursts of words from 4 source FIFOs to 4 destination FIFOs.
// Build option: define MUX_SCHED_FIXED_PRIO_EN for fixed priority 0>1>2>3 instead of round-robin.
module mux_scheduler #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic [3:0] req,
  input  logic [1:0] dest0,
  input  logic [1:0] dest1,
  input  logic [1:0] dest2,
  input  logic [1:0] dest3,
  input  logic [3:0] full,
  output logic [1:0] selectorMux,
  output logic [1:0] selectorDemux,
  output logic [3:0] pop,
  output logic [3:0] push,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE, SERVE, STALL} state_t;

  state_t     state;
  logic [3:0] burst_cnt;
  logic [1:0] last_grant;
  logic [1:0] dest [4];
  logic [1:0] next_grant;
  logic [3:0] cnt_inc;
  logic       xfer;
  logic       burst_done;
  logic       grant_now;

`ifdef MUX_SCHED_FIXED_PRIO_EN
  function automatic logic [1:0] arbitrate(input logic [3:0] r, input logic [1:0] last);
    arbitrate = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) arbitrate = 2'(k);
    end
  endfunction
`else
  function automatic logic [1:0] arbitrate(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    arbitrate = 2'd0;
    found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        arbitrate = idx;
        found     = 1'b1;
      end
    end
  endfunction
`endif

  always_comb begin
    dest[0] = dest0;
    dest[1] = dest1;
    dest[2] = dest2;
    dest[3] = dest3;
  end

  assign next_grant = arbitrate(req, last_grant);
  assign cnt_inc    = burst_cnt + 4'd1;
  assign burst_done = (cnt_inc == 4'(BURST_LEN));

  // Transfer strobes are combinational so a word moves in the same cycle its conditions hold.
  assign xfer  = !reset && enb && (state == SERVE) && req[selectorMux] && !full[selectorDemux];
  assign pop   = xfer ? (4'b0001 << selectorMux)   : 4'b0000;
  assign push  = xfer ? (4'b0001 << selectorDemux) : 4'b0000;
  assign valid = xfer;

  // A new grant is taken from IDLE, or straight out of SERVE when the current grant is released.
  assign grant_now = enb && (|req) &&
                     ((state == IDLE) ||
                      ((state == SERVE) && (!req[selectorMux] || (xfer && burst_done))));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      selectorMux   <= 2'd0;
      selectorDemux <= 2'd0;
      burst_cnt     <= 4'd0;
      last_grant    <= 2'd3;
    end else if (!enb) begin
      state <= IDLE;
    end else if (grant_now) begin
      state         <= SERVE;
      selectorMux   <= next_grant;
      selectorDemux <= dest[next_grant];
      burst_cnt     <= 4'd0;
      last_grant    <= next_grant;
    end else begin
      unique case (state)
        IDLE: state <= IDLE;
        SERVE: begin
          if (!req[selectorMux]) begin
            state <= IDLE;
          end else if (full[selectorDemux]) begin
            state <= STALL;
          end else begin
            burst_cnt     <= cnt_inc;
            selectorDemux <= dest[selectorMux];
          end
        end
        STALL: if (!full[selectorDemux]) state <= SERVE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scheduler.sv
// Randomized self-checking bench for mux_scheduler against a transaction-level reference model.
module tb_mux_scheduler;

  localparam int unsigned BURST_LEN = 4;

  logic       clk = 1'b0;
  logic       reset, enb;
  logic [3:0] req, full;
  logic [1:0] dest0, dest1, dest2, dest3;
  logic [1:0] selectorMux, selectorDemux;
  logic [3:0] pop, push;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;

  mux_scheduler #(.BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset), .enb(enb), .req(req),
    .dest0(dest0), .dest1(dest1), .dest2(dest2), .dest3(dest3),
    .full(full), .selectorMux(selectorMux), .selectorDemux(selectorDemux),
    .pop(pop), .push(push), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: whether a port holds the grant, whether it is waiting on a full
  // destination, which port/destination is selected, words moved so far, last winner.
  bit         m_known = 0;
  bit         m_owned, m_waiting;
  int         m_port, m_dst, m_words, m_last;

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef MUX_SCHED_FIXED_PRIO_EN
    for (int p = 0; p < 4; p++) if (r[p]) return p;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  function automatic int dest_of(input int p);
    case (p)
      0: return int'(dest0);
      1: return int'(dest1);
      2: return int'(dest2);
      default: return int'(dest3);
    endcase
  endfunction

  function automatic bit moving();
    return !reset && enb && m_owned && !m_waiting && req[m_port] && !full[m_dst];
  endfunction

  task automatic take_grant();
    m_port  = pick(req, m_last);
    m_last  = m_port;
    m_dst   = dest_of(m_port);
    m_words = 0;
    m_owned = 1;
  endtask

  task automatic model_update();
    bit mv, done;
    mv = moving();
    if (reset) begin
      m_known = 1; m_owned = 0; m_waiting = 0;
      m_port = 0; m_dst = 0; m_words = 0; m_last = 3;
    end else if (!enb) begin
      m_owned = 0; m_waiting = 0;
    end else if (!m_owned) begin
      if (|req) take_grant();
    end else if (m_waiting) begin
      if (!full[m_dst]) m_waiting = 0;
    end else if (req[m_port] && full[m_dst]) begin
      m_waiting = 1;
    end else begin
      done = !req[m_port];
      if (mv) begin
        m_words++;
        if (m_words == BURST_LEN) done = 1;
        m_dst = dest_of(m_port);
      end
      if (done) begin
        if (|req) take_grant();
        else m_owned = 0;
      end
    end
  endtask

  // Inputs are already applied (just after a falling edge); check, clock, update model.
  task automatic step();
    logic [3:0] e_pop, e_push;
    bit mv;
    #1;
    mv     = moving();
    e_pop  = mv ? 4'(1 << m_port) : 4'd0;
    e_push = mv ? 4'(1 << m_dst)  : 4'd0;
    check("pop", 32'(pop), 32'(e_pop));
    check("push", 32'(push), 32'(e_push));
    check("valid", 32'(valid), 32'(mv));
    check("pop_onehot0", 32'($onehot0(pop)), 32'd1);
    check("valid_vs_push", 32'(valid), 32'(|push));
    if (m_known) begin
      check("selectorMux", 32'(selectorMux), 32'(m_port));
      check("selectorDemux", 32'(selectorDemux), 32'(m_dst));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] f);
    reset = r; enb = e; req = rq; full = f;
    dest0 = 2'($urandom_range(3)); dest1 = 2'($urandom_range(3));
    dest2 = 2'($urandom_range(3)); dest3 = 2'($urandom_range(3));
  endtask

  initial begin
    @(negedge clk);
    drive(1, 0, 4'b0000, 4'b0000);
    step(); step();

    // Single source: port 0 toward destination 3.
    drive(0, 1, 4'b0001, 4'b0000);
    dest0 = 2'd3;
    step();
    #1;
    check("d028_selmux", 32'(selectorMux), 32'd0);
    check("d028_seldemux", 32'(selectorDemux), 32'd3);
    check("d028_pop", 32'(pop), 32'b0001);
    check("d028_push", 32'(push), 32'b1000);
    check("d028_valid", 32'(valid), 32'd1);
    step();

    // All ports requesting: back-to-back bursts with no gap.
    drive(1, 1, 4'b1111, 4'b0000);
    step();
    drive(0, 1, 4'b1111, 4'b0000);
    step();
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, 4'b1111, 4'b0000);
      #1;
`ifdef MUX_SCHED_FIXED_PRIO_EN
      check("d029_burst_pop", 32'(pop), 32'b0001);
`else
      check("d029_burst_pop", 32'(pop), 32'(1 << (((i - 1) / BURST_LEN) % 4)));
`endif
      step();
    end

    // Port 1 to destination 2 with destination full for three cycles.
    drive(1, 1, 4'b0010, 4'b0000);
    step();
    drive(0, 1, 4'b0010, 4'b0000);
    dest1 = 2'd2;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'b0010, 4'b0100);
      dest1 = 2'd2;
      #1;
      check("d030_stall_pop", 32'(pop), 32'd0);
      step();
    end
    drive(0, 1, 4'b0010, 4'b0000);
    dest1 = 2'd2;
    step();
    drive(0, 1, 4'b0010, 4'b0000);
    #1;
    check("d030_resume_pop", 32'(pop), 32'b0010);
    step();

    // Randomized traffic with occasional stalls, enable drops and resets.
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 93, 4'($urandom),
            4'($urandom) & 4'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
